// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: captures RF operands with same-cycle writeback bypass,
// inserts one bubble per load-use hazard, and honours EX hold and branch flush.
module id_ex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ID_VALID,
    input  logic [AW-1:0]    ID_RS1,
    input  logic [AW-1:0]    ID_RS2,
    input  logic [AW-1:0]    ID_RD,
    input  logic             ID_REG_WRITE,
    input  logic             ID_MEM_READ,
    input  logic [XLEN-1:0]  ID_IMM,
    input  logic [XLEN-1:0]  ID_PC,
    input  logic [XLEN-1:0]  RF_DATA1,
    input  logic [XLEN-1:0]  RF_DATA2,
    input  logic             WB_WRITE_ENABLE,
    input  logic [AW-1:0]    WB_ADDRESS,
    input  logic [XLEN-1:0]  WB_DATA,
    input  logic             EX_HOLD,
    input  logic             FLUSH,
    output logic             STALL_IF_ID,
    output logic             EX_VALID,
    output logic [AW-1:0]    EX_RS1,
    output logic [AW-1:0]    EX_RS2,
    output logic [AW-1:0]    EX_RD,
    output logic             EX_REG_WRITE,
    output logic             EX_MEM_READ,
    output logic [XLEN-1:0]  EX_OP1,
    output logic [XLEN-1:0]  EX_OP2,
    output logic [XLEN-1:0]  EX_IMM,
    output logic [XLEN-1:0]  EX_PC,
    output logic [CNT_W-1:0] BUBBLE_COUNT
);

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] byp1;
    logic [XLEN-1:0] byp2;
    logic            luh;
    logic            insert_bubble;

    function automatic logic [XLEN-1:0] bypass(
        input logic [AW-1:0]   rs,
        input logic [XLEN-1:0] rf,
        input logic            we,
        input logic [AW-1:0]   wa,
        input logic [XLEN-1:0] wd
    );
        if (rs == '0)
            return '0;
        else if (we && (wa == rs))
            return wd;
        else
            return rf;
    endfunction

    // x0 is never refreshed, even if writeback names it.
    function automatic logic refresh_hit(
        input logic          we,
        input logic [AW-1:0] wa,
        input logic [AW-1:0] rs
    );
        return we && (wa != '0) && (wa == rs);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign byp1 = bypass(ID_RS1, RF_DATA1, WB_WRITE_ENABLE, WB_ADDRESS, WB_DATA);
    assign byp2 = bypass(ID_RS2, RF_DATA2, WB_WRITE_ENABLE, WB_ADDRESS, WB_DATA);

    assign luh = ID_VALID && EX_VALID && EX_MEM_READ && (EX_RD != '0) &&
                 ((EX_RD == ID_RS1) || (EX_RD == ID_RS2));

    assign insert_bubble = luh && (state_q == RUN);

    assign STALL_IF_ID = !RESET && (EX_HOLD || (insert_bubble && !FLUSH));

    always_comb begin
        state_d = state_q;
        if (FLUSH)
            state_d = RUN;
        else if (EX_HOLD)
            state_d = state_q;
        else if (insert_bubble)
            state_d = BUBBLE;
        else
            state_d = RUN;
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // ID -> EX register boundary
    always_ff @(posedge CLK) begin
        if (RESET) begin
            EX_VALID     <= 1'b0;
            EX_RS1       <= '0;
            EX_RS2       <= '0;
            EX_RD        <= '0;
            EX_REG_WRITE <= 1'b0;
            EX_MEM_READ  <= 1'b0;
            EX_OP1       <= '0;
            EX_OP2       <= '0;
            EX_IMM       <= '0;
            EX_PC        <= '0;
            BUBBLE_COUNT <= '0;
        end else if (FLUSH) begin
            EX_VALID     <= 1'b0;
            EX_RS1       <= '0;
            EX_RS2       <= '0;
            EX_RD        <= '0;
            EX_REG_WRITE <= 1'b0;
            EX_MEM_READ  <= 1'b0;
        end else if (EX_HOLD) begin
            if (refresh_hit(WB_WRITE_ENABLE, WB_ADDRESS, EX_RS1))
                EX_OP1 <= WB_DATA;
            if (refresh_hit(WB_WRITE_ENABLE, WB_ADDRESS, EX_RS2))
                EX_OP2 <= WB_DATA;
        end else if (insert_bubble) begin
            // Clearing the addresses keeps EX forwarding from matching the bubble.
            EX_VALID     <= 1'b0;
            EX_RS1       <= '0;
            EX_RS2       <= '0;
            EX_RD        <= '0;
            EX_REG_WRITE <= 1'b0;
            EX_MEM_READ  <= 1'b0;
            BUBBLE_COUNT <= sat_inc(BUBBLE_COUNT);
        end else begin
            EX_VALID     <= ID_VALID;
            EX_RS1       <= ID_RS1;
            EX_RS2       <= ID_RS2;
            EX_RD        <= ID_RD;
            EX_REG_WRITE <= ID_VALID && ID_REG_WRITE;
            EX_MEM_READ  <= ID_VALID && ID_MEM_READ;
            EX_OP1       <= byp1;
            EX_OP2       <= byp2;
            EX_IMM       <= ID_IMM;
            EX_PC        <= ID_PC;
        end
    end

endmodule
